alu_control: RTL

ALU_CONTROL -- requirements
Module: alu_control

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/alu_op_decode.sv | 31 +++
 rtl/alu_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, ALU control state encoding and default abort limit.
package cpu_pkg;

    localparam int unsigned WAIT_LIMIT_DEFAULT = 63;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        StIdle,
        StLoadY,
        StExec,
        StWait,
        StWbLo,
        StWbHi,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legal, unary (single operand) and long (iterative mul/div).
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal,
    output logic       is_unary,
    output logic       is_long
);

    always_comb begin
        legal    = 1'b0;
        is_unary = 1'b0;
        is_long  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                legal = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                legal   = 1'b1;
                is_long = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                legal    = 1'b1;
                is_unary = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// ALU sequencing FSM: drives operand loads, execution, optional iterative wait with abort,
// and lo/hi or rd writeback. illegal and timeout are registered pulses seen the cycle after.
module alu_control
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] instr_op,
    input  logic       alu_done,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       timeout,
    output logic [4:0] alu_op,
    output logic       alu_start,
    output logic       ra_out,
    output logic       rb_out,
    output logic       y_in,
    output logic       z_in,
    output logic       zlo_out,
    output logic       zhi_out,
    output logic       rd_in,
    output logic       lo_in,
    output logic       hi_in
);

    localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(WAIT_LIMIT);

    ctrl_state_e     state_q, state_d;
    logic [4:0]      op_reg_q, op_reg_d;
    logic            long_q, long_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic dec_legal, dec_unary, dec_long;

    alu_op_decode u_decode (
        .op       (instr_op),
        .legal    (dec_legal),
        .is_unary (dec_unary),
        .is_long  (dec_long)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= StIdle;
            op_reg_q   <= '0;
            long_q     <= 1'b0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_reg_q   <= op_reg_d;
            long_q     <= long_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_reg_d   = op_reg_q;
        long_d     = long_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        alu_op     = '0;
        alu_start  = 1'b0;
        done       = 1'b0;
        ra_out     = 1'b0;
        rb_out     = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlo_out    = 1'b0;
        zhi_out    = 1'b0;
        rd_in      = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (dec_legal) begin
                        op_reg_d = instr_op;
                        long_d   = dec_long;
                        state_d  = dec_unary ? StExec : StLoadY;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StLoadY: begin
                ra_out  = 1'b1;
                y_in    = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                rb_out     = 1'b1;
                alu_op     = op_reg_q;
                wait_cnt_d = '0;
                if (long_q) begin
                    alu_start = 1'b1;
                    state_d   = StWait;
                end else begin
                    z_in    = 1'b1;
                    state_d = StWbLo;
                end
            end
            StWait: begin
                rb_out     = 1'b1;
                alu_op     = op_reg_q;
                // Saturate so the count never wraps back to zero.
                wait_cnt_d = (wait_cnt_q == Limit) ? wait_cnt_q : wait_cnt_q + 1'b1;
                if (alu_done) begin
                    z_in    = 1'b1;
                    state_d = StWbLo;
                end else if (wait_cnt_d == Limit) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWbLo: begin
                zlo_out = 1'b1;
                if (long_q) begin
                    lo_in   = 1'b1;
                    state_d = StWbHi;
                end else begin
                    rd_in   = 1'b1;
                    state_d = StDone;
                end
            end
            StWbHi: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule
